// File: rtl/sprite_palette_bank.sv
// rtl/sprite_palette_bank.sv - run-time writable multi-palette sprite colour lookup, 1-cycle registered output
// Optional damage-flash effect built only when PALETTE_FLASH_EN is defined.
module sprite_palette_bank #(
  parameter int IDX_W        = 3,
  parameter int NUM_PAL      = 4,
  parameter int COLOR_W      = 4,
  parameter int FLASH_FRAMES = 16,
  localparam int PAL_W       = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 pix_valid,
  input  logic [PAL_W-1:0]     pal_sel,
  input  logic [IDX_W-1:0]     index,
  input  logic                 wr_en,
  input  logic [PAL_W-1:0]     wr_pal,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [3*COLOR_W-1:0] wr_data,
  input  logic                 frame_start,
  input  logic                 flash_trig,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 out_valid,
  output logic                 transparent,
  output logic                 flash_active
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int DW    = 3 * COLOR_W;
  localparam logic [PAL_W:0] NUM_PAL_L = (PAL_W + 1)'(NUM_PAL);
  localparam logic [7:0]     FLASH_LOAD = 8'(FLASH_FRAMES);

  // Map a 4-bit reference nibble onto COLOR_W bits, MSB-aligned.
  function automatic logic [COLOR_W-1:0] widen(input logic [3:0] n);
    logic [COLOR_W-1:0] c;
    c = '0;
    for (int b = 0; b < 4; b++) begin
      if (COLOR_W - 1 - b >= 0) c[COLOR_W-1-b] = n[3-b];
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] default_entry(input int i);
    logic [11:0] n;
    case (i)
      0:       n = 12'h0E1;
      1:       n = 12'h050;
      2:       n = 12'hC20;
      3:       n = 12'hD98;
      4:       n = 12'h754;
      5:       n = 12'h000;
      6:       n = 12'h610;
      7:       n = 12'h0A0;
      default: n = 12'h000;
    endcase
    return {widen(n[11:8]), widen(n[7:4]), widen(n[3:0])};
  endfunction

  logic [DW-1:0]    mem [NUM_PAL][DEPTH];
  logic             wr_ok;
  logic [PAL_W-1:0] rd_pal;
  logic [DW-1:0]    rd_entry;
  logic             white_en;

  assign wr_ok    = wr_en && ({1'b0, wr_pal} < NUM_PAL_L);
  assign rd_pal   = ({1'b0, pal_sel} < NUM_PAL_L) ? pal_sel : '0;
  assign rd_entry = mem[rd_pal][index];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[p][i] <= default_entry(i);
        end
      end
    end else if (wr_ok) begin
      mem[wr_pal][wr_idx] <= wr_data;
    end
  end

  // Lookup reads the array before this edge's write lands, giving read-before-write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      out_valid   <= 1'b0;
      transparent <= 1'b0;
    end else begin
      out_valid <= pix_valid;
      if (pix_valid) begin
        transparent <= (index == '0);
        if (white_en && (index != '0)) begin
          {red, green, blue} <= '1;
        end else begin
          {red, green, blue} <= rd_entry;
        end
      end
    end
  end

`ifdef PALETTE_FLASH_EN
  typedef enum logic {IDLE, FLASH} state_t;

  state_t     state, state_n;
  logic [7:0] fcnt, fcnt_n;
  logic       phase, phase_n;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      fcnt  <= 8'd0;
      phase <= 1'b0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      phase <= phase_n;
    end
  end

  // A trigger always reloads, even on a frame boundary.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    phase_n = phase;
    if (flash_trig) begin
      state_n = FLASH;
      fcnt_n  = FLASH_LOAD;
      phase_n = 1'b1;
    end else if ((state == FLASH) && frame_start) begin
      if (fcnt == 8'd1) begin
        state_n = IDLE;
        fcnt_n  = 8'd0;
        phase_n = 1'b0;
      end else begin
        fcnt_n  = fcnt - 8'd1;
        phase_n = ~phase;
      end
    end
  end

  assign flash_active = (state == FLASH);
  assign white_en     = phase;
`else
  logic unused_flash;

  assign unused_flash = ^{frame_start, flash_trig, FLASH_LOAD};
  assign flash_active = 1'b0;
  assign white_en     = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb/tb_sprite_palette_bank.sv - scoreboard bench for sprite_palette_bank (NUM_PAL=3, FLASH_FRAMES=4)
module tb_sprite_palette_bank;

  localparam int PAL_W = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [1:0]  pal_sel = '0;
  logic [2:0]  index = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_pal = '0;
  logic [2:0]  wr_idx = '0;
  logic [11:0] wr_data = '0;
  logic        frame_start = 1'b0;
  logic        flash_trig = 1'b0;
  logic [3:0]  red, green, blue;
  logic        out_valid, transparent, flash_active;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        t;
    string       nm;
  } exp_t;

  exp_t exp_q[$];

  sprite_palette_bank #(
    .IDX_W(3), .NUM_PAL(3), .COLOR_W(4), .FLASH_FRAMES(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pal_sel(pal_sel),
    .index(index), .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx),
    .wr_data(wr_data), .frame_start(frame_start), .flash_trig(flash_trig),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .transparent(transparent), .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every presented output consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n && out_valid) begin
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_out_valid: got 1 want 0");
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_rgb"}, {red, green, blue}, e.rgb);
          chk({e.nm, "_transp"}, {11'd0, transparent}, {11'd0, e.t});
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    pix_valid   = 1'b0;
    wr_en       = 1'b0;
    frame_start = 1'b0;
    flash_trig  = 1'b0;
  endtask

  task automatic look(input int pal, input int idx, input logic [11:0] exp, input string nm);
    exp_t e;
    pix_valid = 1'b1;
    pal_sel   = PAL_W'(pal);
    index     = 3'(idx);
    e.rgb = exp;
    e.t   = (idx == 0);
    e.nm  = nm;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic wr(input int pal, input int idx, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_pal  = PAL_W'(pal);
    wr_idx  = 3'(idx);
    wr_data = d;
  endtask

  logic [11:0] dflt [8];

  initial begin
    dflt[0] = 12'h0E1; dflt[1] = 12'h050; dflt[2] = 12'hC20; dflt[3] = 12'hD98;
    dflt[4] = 12'h754; dflt[5] = 12'h000; dflt[6] = 12'h610; dflt[7] = 12'h0A0;

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_rgb", {red, green, blue}, 12'h000);
    chk("reset_valid", {11'd0, out_valid}, 12'h000);
    chk("reset_transp", {11'd0, transparent}, 12'h000);
    chk("reset_flash", {11'd0, flash_active}, 12'h000);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) look(0, i, dflt[i], $sformatf("default_p0_i%0d", i));
    pal_sel = 2'd1;
    index   = 3'd2;
    tick();
    chk("hold_valid", {11'd0, out_valid}, 12'h000);
    chk("hold_rgb", {red, green, blue}, 12'h0A0);

    wr(2, 3, 12'hABC);
    look(2, 3, 12'hD98, "raw_same_cycle");
    look(2, 3, 12'hABC, "raw_next_cycle");
    look(1, 3, 12'hD98, "other_pal_untouched");

    wr(3, 1, 12'hFFF);
    tick();
    look(0, 1, 12'h050, "oob_wr_p0");
    look(1, 1, 12'h050, "oob_wr_p1");
    look(2, 1, 12'h050, "oob_wr_p2");
    wr(0, 4, 12'h123);
    tick();
    look(3, 4, 12'h123, "oob_rd_uses_p0");
    look(1, 4, 12'h754, "p1_idx4");

`ifdef PALETTE_FLASH_EN
    flash_trig = 1'b1;
    look(0, 2, 12'hC20, "trig_cycle");
    chk("flash_rise", {11'd0, flash_active}, 12'h001);
    look(0, 2, 12'hFFF, "fl_a");
    look(0, 0, 12'h0E1, "fl_transp");
    frame_start = 1'b1; look(0, 2, 12'hFFF, "fl_f1");
    look(0, 2, 12'hC20, "fl_b");
    frame_start = 1'b1; look(0, 0, 12'h0E1, "fl_f2_transp");
    look(0, 2, 12'hFFF, "fl_c");
    frame_start = 1'b1; look(0, 2, 12'hFFF, "fl_f3");
    look(0, 2, 12'hC20, "fl_d");
    chk("flash_before_last", {11'd0, flash_active}, 12'h001);
    frame_start = 1'b1; look(0, 2, 12'hC20, "fl_f4");
    chk("flash_fall", {11'd0, flash_active}, 12'h000);
    look(0, 2, 12'hC20, "fl_after");

    flash_trig = 1'b1; look(0, 2, 12'hC20, "re_trig");
    frame_start = 1'b1; look(0, 2, 12'hFFF, "re_f1");
    look(0, 2, 12'hC20, "re_a");
    frame_start = 1'b1; flash_trig = 1'b1; look(0, 2, 12'hC20, "coincide");
    look(0, 2, 12'hFFF, "coincide_phase1");
    frame_start = 1'b1; look(0, 2, 12'hFFF, "rl_f1");
    frame_start = 1'b1; look(0, 2, 12'hC20, "rl_f2");
    frame_start = 1'b1; look(0, 2, 12'hFFF, "rl_f3");
    chk("reload_still_active", {11'd0, flash_active}, 12'h001);
    look(0, 2, 12'hC20, "rl_b");
`else
    flash_trig = 1'b1;
    look(0, 2, 12'hC20, "nf_trig");
    chk("nf_flash_low", {11'd0, flash_active}, 12'h000);
    look(0, 2, 12'hC20, "nf_a");
    frame_start = 1'b1; look(0, 2, 12'hC20, "nf_f1");
    chk("nf_flash_low2", {11'd0, flash_active}, 12'h000);
`endif

    tick();
    tick();
    chk("drain", 12'(exp_q.size()), 12'h000);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midreset_rgb", {red, green, blue}, 12'h000);
    chk("midreset_flash", {11'd0, flash_active}, 12'h000);
    chk("midreset_transp", {11'd0, transparent}, 12'h000);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    look(2, 3, 12'hD98, "post_reset_p2_i3");
    look(0, 4, 12'h754, "post_reset_p0_i4");
    look(1, 5, 12'h000, "post_reset_p1_i5");
    chk("post_reset_flash", {11'd0, flash_active}, 12'h000);
    tick();
    tick();
    chk("final_drain", 12'(exp_q.size()), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Parametrised, run-time-writable sprite colour lookup that replaces the fixed per-sprite palette modules. It holds NUM_PAL palettes of 2^IDX_W entries each. It maps a sprite pixel index to registered RGB with a transparency flag, and optionally applies a per-frame damage-flash effect. It sits between the sprite ROM readers and the VGA colour mux.

## Interface
Parameters:
- IDX_W, 3: index width; palette depth 2^IDX_W.
- NUM_PAL, 4: number of palettes, ≥1; PAL_W = max(1, $clog2(NUM_PAL)).
- COLOR_W, 4: bits per channel.
- FLASH_FRAMES, 16: frames a flash lasts, 1..255.

Ports (clock and reset first):
- Clk  in  1  system clock.
- Reset_n  in  1  reset, asynchronous, active-low.
- pix_valid  in  1  lookup request this cycle.
- pal_sel  in  PAL_W  palette for the lookup.
- index  in  IDX_W  pixel index.
- wr_en  in  1  palette write strobe.
- wr_pal  in  PAL_W  palette to write.
- wr_idx  in  IDX_W  entry to write.
- wr_data  in  3*COLOR_W  {red, green, blue} to write.
- frame_start  in  1  one-cycle pulse per video frame.
- flash_trig  in  1  start or restart the flash.
- red, green, blue  out  COLOR_W each  registered colour.
- out_valid  out  1  registered pix_valid.
- transparent  out  1  registered flag (index == 0).
- flash_active  out  1  flash state machine is in FLASH.

## Operation
- Storage is a register array NUM_PAL × 2^IDX_W × 3*COLOR_W.
- On reset, every palette loads the default enemy set, with entries 0..7 = 0E1, 050, C20, D98, 754, 000, 610, 0A0. Entries beyond 7 load 000. When COLOR_W≠4, each nibble is left-aligned and zero-padded.
- Write: when wr_en=1 and wr_pal<NUM_PAL, entry [wr_pal][wr_idx] ← wr_data at the clock edge. When wr_pal≥NUM_PAL, the write is ignored.
- Lookup: the output registers capture palette[pal_sel][index], out_valid ← pix_valid, and transparent ← (index==0). When pal_sel≥NUM_PAL, lookup uses palette 0.
- When pix_valid=0, out_valid=0 and colour/transparent hold their previous values.
- Write and read of the same entry in the same cycle: the lookup returns the pre-write value. The new value is visible to a lookup issued on the next cycle.
- Flash FSM, states IDLE and FLASH. A frame counter fcnt (8 bit) and a phase bit run alongside it.
  - flash_trig=1 from any state: go to FLASH, fcnt←FLASH_FRAMES, phase←1.
  - In FLASH with frame_start=1 and no trigger: fcnt←fcnt-1 and phase toggles. When fcnt==1, go to IDLE, fcnt←0, phase←0.
  - flash_trig and frame_start in the same cycle: the trigger wins (reload, no decrement).
- While phase=1, a lookup with index≠0 outputs all channels at full scale ({COLOR_W{1'b1}}) instead of the palette colour. Transparent pixels are unaffected.

## Timing
- Lookup latency is 1 cycle, fully pipelined, one lookup per cycle.
- A write takes effect at the edge; the first lookup that sees it is the one issued the following cycle.
- A flash takes effect on lookups issued the cycle after flash_trig. flash_active rises 1 cycle after flash_trig.
- A flash lasts exactly FLASH_FRAMES frame_start pulses after the trigger, then flash_active falls 1 cycle after the final pulse.
- Reset values: red/green/blue=0, out_valid=0, transparent=0, flash_active=0, FSM=IDLE, fcnt=0, phase=0, palettes=default set.
- Reset asserted mid-flash or mid-write aborts immediately. The asynchronous reset restores all of the above.

## Configuration
- PALETTE_FLASH_EN defined: flash FSM, counter and white override are built as described.
- PALETTE_FLASH_EN undefined: no flash logic is generated. frame_start and flash_trig are ignored, flash_active is tied to 0, and output is always the palette colour.

## Test plan
- Reset, then look up pal 0 with index 0..7 → colours 0E1, 050, C20, D98, 754, 000, 610, 0A0 one cycle later. transparent=1 only for index 0; out_valid follows pix_valid.
- Write pal 2 idx 3 = ABC while looking up pal 2 idx 3 in the same cycle → D98. Repeat the lookup next cycle → ABC. Pal 1 idx 3 is still D98.
- wr_pal=NUM_PAL with data FFF → no entry changes. Lookup with pal_sel=NUM_PAL (NUM_PAL=3 build) → palette 0 contents.
- PALETTE_FLASH_EN defined, FLASH_FRAMES=4, trigger, then 4 frame_start pulses with continuous index 2 lookups → FFF, C20, FFF, C20 across the frame phases. flash_active falls after the 4th pulse. Index 0 stays 0E1 with transparent=1 throughout.
- flash_trig coincident with frame_start mid-flash → fcnt reloads to FLASH_FRAMES and phase=1. Assert Reset_n low mid-flash → flash_active=0 and outputs=0 immediately.
- PALETTE_FLASH_EN undefined, pulse flash_trig → flash_active stays 0 and colours stay unchanged.
